alu_sequencer: RTL and testbench

Multi-cycle operation sequencer that sits directly in front of the 16×8 register unit. It accepts one register-to-register instruction (opcode, two source addresses, one destination address) and reads the operands through the register unit's single addr/data_out port. It then computes an 8-bit result with flags and writes the result back through the load/data_in port. It owns the register unit's addr, load and data_in inputs whenever it is busy.

---
 rtl/alu_seq_pkg.sv | 60 ++++++
 rtl/alu_core.sv | 114 +++++++++++
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
//   Shared definitions for the ALU sequencer and its combinational ALU core:
//   opcode encoding, sequencer state encoding, flag bit positions and the
//   default datapath widths.
//
//   Contents:
//     DATA_W_DEF / ADDR_W_DEF   default operand width / register address width
//     FLAG_Z/C/V/N              bit positions inside the 4-bit flags vector
//     opcode_t                  4-bit opcode encoding (0x0..0xB legal)
//     state_t                   sequencer states
//     op_is_legal / op_is_unary opcode classification helpers
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_NOT = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_INC = 4'h8,
        OP_DEC = 4'h9,
        OP_MOV = 4'hA,
        OP_CMP = 4'hB
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR_A = 3'd1,
        S_LAT_A  = 3'd2,
        S_ADDR_B = 3'd3,
        S_LAT_B  = 3'd4,
        S_EXEC   = 3'd5,
        S_WRITE  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    // Encodings 0xC..0xF are reserved and rejected at accept time.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op < 4'hC);
    endfunction

    // Single-operand instructions skip the second register read.
    function automatic logic op_is_unary(input logic [3:0] op);
        return (op >= 4'h5) && (op <= 4'hA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU. Produces the result and {N,V,C,Z} flags for one
//   opcode applied to operands a and b. The sequencer registers both outputs.
//
//   Ports:
//     opcode  in  4       operation (see alu_seq_pkg::opcode_t)
//     a       in  DATA_W  first operand (the only operand for unary ops)
//     b       in  DATA_W  second operand (ignored by unary ops)
//     result  out DATA_W  computed value
//     flags   out 4       {N,V,C,Z}, indexed by FLAG_* from the package
//
//   Carry semantics: ADD/INC carry-out, SUB/DEC/CMP borrow (a < b unsigned),
//   SHL shifted-out MSB, SHR shifted-out LSB, zero for logic ops and MOV.
// -----------------------------------------------------------------------------
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [DATA_W-1:0] res_s;
    logic        [DATA_W:0]   wide;
    logic                     carry;
    logic                     ovf;

    assign a_s = a;
    assign b_s = b;

    // Two's-complement overflow: operands of equal sign giving a result of the
    // other sign.
    function automatic logic add_ovf(input logic signed [DATA_W-1:0] x,
                                     input logic signed [DATA_W-1:0] y,
                                     input logic signed [DATA_W-1:0] r);
        return (x[DATA_W-1] == y[DATA_W-1]) && (r[DATA_W-1] != x[DATA_W-1]);
    endfunction

    // Subtraction overflows when operand signs differ and the result takes the
    // subtrahend's sign.
    function automatic logic sub_ovf(input logic signed [DATA_W-1:0] x,
                                     input logic signed [DATA_W-1:0] y,
                                     input logic signed [DATA_W-1:0] r);
        return (x[DATA_W-1] != y[DATA_W-1]) && (r[DATA_W-1] != x[DATA_W-1]);
    endfunction

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (opcode)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                ovf    = add_ovf(a_s, b_s, wide[DATA_W-1:0]);
            end
            OP_SUB, OP_CMP: begin
                // Bit DATA_W of the widened difference is the borrow.
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                ovf    = sub_ovf(a_s, b_s, wide[DATA_W-1:0]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            OP_INC: begin
                wide   = {1'b0, a} + {1'b0, ONE};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                ovf    = add_ovf(a_s, ONE, wide[DATA_W-1:0]);
            end
            OP_DEC: begin
                wide   = {1'b0, a} - {1'b0, ONE};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                ovf    = sub_ovf(a_s, ONE, wide[DATA_W-1:0]);
            end
            OP_MOV: result = a;
            default: result = '0;
        endcase
    end

    assign res_s = result;

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
        flags[FLAG_N] = res_s[DATA_W-1];
    end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Multi-cycle register-to-register instruction sequencer in front of a
//   16x8 register unit with a single synchronous read port (addr -> data_out
//   one cycle later) and a load/data_in write port.
//
//   Ports:
//     clock      in   system clock, all state changes on the rising edge
//     reset      in   synchronous active-high reset
//     start      in   request; only accepted in IDLE
//     opcode     in   4-bit operation, latched on accept
//     src_a      in   ADDR_W first source register, latched on accept
//     src_b      in   ADDR_W second source register, latched on accept
//     dst        in   ADDR_W destination register, latched on accept
//     busy       out  high in every state except IDLE (registered)
//     done       out  one-cycle pulse in DONE (registered)
//     err        out  qualifies done; 1 = illegal opcode (registered)
//     result     out  DATA_W last computed value, updated in EXEC
//     flags      out  {N,V,C,Z} of the last computation, updated in EXEC
//     reg_addr   out  ADDR_W register unit address
//     reg_load   out  register unit write enable
//     reg_wdata  out  DATA_W register unit write data
//     reg_rdata  in   DATA_W register unit read data
//
//   Sequence: IDLE -> ADDR_A -> LAT_A -> [ADDR_B -> LAT_B] -> EXEC -> [WRITE]
//   -> DONE -> IDLE. Unary ops skip the B read, CMP skips the write, illegal
//   opcodes go straight from IDLE to DONE with err set.
//   reg_* outputs are decoded from the state register and latched fields only,
//   so there is no combinational path from start to the register unit.
// -----------------------------------------------------------------------------
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_load,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata
);

    state_t state;
    state_t state_next;

    logic [3:0]        op_q;
    logic [ADDR_W-1:0] src_a_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;

    // Operand B is stale for unary ops; the core ignores it for those opcodes.
    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode (op_q),
        .a      (opnd_a),
        .b      (opnd_b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = op_is_legal(opcode) ? S_ADDR_A : S_DONE;
                end
            end
            S_ADDR_A: state_next = S_LAT_A;
            S_LAT_A:  state_next = op_is_unary(op_q) ? S_EXEC : S_ADDR_B;
            S_ADDR_B: state_next = S_LAT_B;
            S_LAT_B:  state_next = S_EXEC;
            S_EXEC:   state_next = (op_q == OP_CMP) ? S_DONE : S_WRITE;
            S_WRITE:  state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Register unit drive. Outside ADDR_B and WRITE the address parks on the
    // latched src_a, which also covers the ADDR_A read.
    always_comb begin
        reg_addr  = src_a_q;
        reg_load  = 1'b0;
        reg_wdata = '0;
        case (state)
            S_ADDR_B: reg_addr = src_b_q;
            S_WRITE: begin
                reg_addr  = dst_q;
                reg_load  = 1'b1;
                reg_wdata = result;
            end
            default: ;
        endcase
    end

    // Status outputs are registered from the next state so they line up with
    // the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
            flags   <= '0;
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            opnd_a  <= '0;
            opnd_b  <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
            done  <= (state_next == S_DONE);
            // Only an illegal opcode reaches DONE directly from IDLE.
            err   <= (state == S_IDLE) && (state_next == S_DONE);

            if (state == S_IDLE && start) begin
                op_q    <= opcode;
                src_a_q <= src_a;
                src_b_q <= src_b;
                dst_q   <= dst;
            end
            if (state == S_LAT_A) begin
                opnd_a <= reg_rdata;
            end
            if (state == S_LAT_B) begin
                opnd_b <= reg_rdata;
            end
            if (state == S_EXEC) begin
                result <= alu_result;
                flags  <= alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Bench for alu_sequencer with an attached 16x8 register unit, a cycle-level
//   behavioural model computed from opcode arithmetic and latency classes, a
//   per-cycle compare process, directed scenarios and randomized instructions.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [3:0] src_a = 4'h0;
    logic [3:0] src_b = 4'h0;
    logic [3:0] dst = 4'h0;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic [3:0] flags;
    logic [3:0] reg_addr;
    logic       reg_load;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    alu_sequencer #(.DATA_W(8), .ADDR_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .src_a     (src_a),
        .src_b     (src_b),
        .dst       (dst),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result),
        .flags     (flags),
        .reg_addr  (reg_addr),
        .reg_load  (reg_load),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    always #5 clock = ~clock;

    // Register unit: synchronous read, write on load, plus a bench preload port.
    logic [7:0] rf [16] = '{default: 8'h00};
    logic       pl_en = 1'b0;
    logic [3:0] pl_addr = 4'h0;
    logic [7:0] pl_data = 8'h00;

    always @(posedge clock) begin
        reg_rdata <= rf[reg_addr];
        if (reg_load) rf[reg_addr] <= reg_wdata;
        else if (pl_en) rf[pl_addr] <= pl_data;
    end

    // Reference arithmetic on plain integers: returns {N,V,C,Z, result}.
    function automatic logic [11:0] model_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, sa, sb, full, sfull;
        logic c, v;
        logic [7:0] r;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        full = 0;
        sfull = 0;
        c = 1'b0;
        case (op)
            4'h0: begin full = ia + ib; sfull = sa + sb; c = (full > 255); end
            4'h1, 4'hB: begin full = ia - ib; sfull = sa - sb; c = (ia < ib); end
            4'h2: full = ia & ib;
            4'h3: full = ia | ib;
            4'h4: full = ia ^ ib;
            4'h5: full = 255 - ia;
            4'h6: begin full = ia * 2; c = (ia >= 128); end
            4'h7: begin full = ia / 2; c = (ia % 2 == 1); end
            4'h8: begin full = ia + 1; sfull = sa + 1; c = (full > 255); end
            4'h9: begin full = ia - 1; sfull = sa - 1; c = (ia == 0); end
            4'hA: full = ia;
            default: full = 0;
        endcase
        v = (sfull > 127) || (sfull < -128);
        r = full[7:0];
        return {r[7], v, c, (r == 8'h00), r};
    endfunction

    // Cycle in which done appears, counted from the accept edge.
    function automatic int lat(input logic [3:0] op);
        if (op >= 4'hC) return 1;
        if (op == 4'hB) return 6;
        if (op >= 4'h5) return 5;
        return 7;
    endfunction

    // Model state: m_k is the cycle number since accept (0 = idle).
    int         m_k = 0;
    int         m_len = 0;
    logic       m_illegal = 1'b0;
    logic       m_write = 1'b0;
    logic       m_binary = 1'b0;
    logic [3:0] m_sa = 4'h0;
    logic [3:0] m_sb = 4'h0;
    logic [3:0] m_dst = 4'h0;
    logic [11:0] m_out = 12'h000;
    logic [7:0] m_res_vis = 8'h00;
    logic [3:0] m_flags_vis = 4'h0;
    logic [7:0] mregs [16] = '{default: 8'h00};

    always @(posedge clock) begin
        if (m_k != 0 && m_write && m_k == m_len - 1) mregs[m_dst] <= m_out[7:0];
        else if (pl_en) mregs[pl_addr] <= pl_data;

        if (reset) begin
            m_k <= 0;
            m_res_vis <= 8'h00;
            m_flags_vis <= 4'h0;
        end else if (m_k == 0) begin
            if (start) begin
                m_k <= 1;
                m_len <= lat(opcode);
                m_illegal <= (opcode >= 4'hC);
                m_write <= (opcode < 4'hB);
                m_binary <= (opcode < 4'h5) || (opcode == 4'hB);
                m_sa <= src_a;
                m_sb <= src_b;
                m_dst <= dst;
                m_out <= model_op(opcode, mregs[src_a], mregs[src_b]);
            end
        end else begin
            m_k <= (m_k == m_len) ? 0 : m_k + 1;
            // Result becomes visible in the WRITE cycle, or in DONE for CMP.
            if (!m_illegal && (m_k + 1 == (m_write ? m_len - 1 : m_len))) begin
                m_res_vis <= m_out[7:0];
                m_flags_vis <= m_out[11:8];
            end
        end
    end

    logic e_busy, e_done, e_err, e_load;
    assign e_busy = (m_k != 0);
    assign e_done = e_busy && (m_k == m_len);
    assign e_err  = e_done && m_illegal;
    assign e_load = e_busy && m_write && (m_k == m_len - 1);

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    // Literal expectations posted by the directed sequence, consumed below.
    string       pin_name [512];
    logic [31:0] pin_got  [512];
    logic [31:0] pin_want [512];
    int          pin_wr = 0;
    int          pin_rd = 0;

    function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, got, want, $time);
        end
    endfunction

    function automatic int rf_diff();
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) if (rf[i] !== mregs[i]) n++;
        return n;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("err", 32'(err), 32'(e_err));
            chk("reg_load", 32'(reg_load), 32'(e_load));
            chk("result", 32'(result), 32'(m_res_vis));
            chk("flags", 32'(flags), 32'(m_flags_vis));
            if (e_load) begin
                chk("write_addr", 32'(reg_addr), 32'(m_dst));
                chk("write_data", 32'(reg_wdata), 32'(m_out[7:0]));
            end
            if (e_busy && !m_illegal && m_k == 1) chk("addr_a", 32'(reg_addr), 32'(m_sa));
            if (e_busy && m_binary && m_k == 3) chk("addr_b", 32'(reg_addr), 32'(m_sb));
            chk("regfile_diff", 32'(rf_diff()), 32'd0);
        end
        while (pin_rd < pin_wr) begin
            chk(pin_name[pin_rd], pin_got[pin_rd], pin_want[pin_rd]);
            pin_rd++;
        end
    end

    task automatic pin(input string n, input logic [31:0] got, input logic [31:0] want);
        if (pin_wr < 512) begin
            pin_name[pin_wr] = n;
            pin_got[pin_wr] = got;
            pin_want[pin_wr] = want;
            pin_wr++;
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] v);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = v;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    // Issues one instruction from IDLE; mask bit c pulses start in cycle c.
    // Returns in the IDLE cycle after done.
    task automatic run_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] d, input logic [15:0] mask,
                          output int done_at, output int loads, output logic err_seen);
        opcode = op;
        src_a = a;
        src_b = b;
        dst = d;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        done_at = 0;
        loads = 0;
        err_seen = 1'b0;
        for (int c = 1; c <= 20 && done_at == 0; c++) begin
            if (reg_load) loads++;
            if (done) begin
                done_at = c;
                err_seen = err;
            end else begin
                start = (c < 16) && mask[c[3:0]];
                if (start) begin
                    opcode = 4'($urandom);
                    src_a = 4'($urandom);
                    src_b = 4'($urandom);
                    dst = 4'($urandom);
                end
                @(posedge clock); #1;
                start = 1'b0;
            end
        end
        if (done_at == 0) pin("done_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
    endtask

    function automatic logic [7:0] pick_data();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            4: return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_at, ld;
        logic e_s;
        repeat (2) @(posedge clock);
        #1;
        pin("reset_outputs", 32'({busy, done, err, result, flags, reg_addr, reg_load, reg_wdata}), 32'd0);
        chk_en = 1'b1;
        reset = 1'b0;
        @(posedge clock); #1;

        // ADD 0x7F + 0x01 -> r3
        preload(4'd1, 8'h7F);
        preload(4'd2, 8'h01);
        run_op(4'h0, 4'd1, 4'd2, 4'd3, 16'h0000, d_at, ld, e_s);
        pin("add_done_cycle", 32'(d_at), 32'd7);
        pin("add_loads", 32'(ld), 32'd1);
        pin("add_r3", 32'(rf[3]), 32'h80);
        pin("add_result", 32'(result), 32'h80);
        pin("add_flags", 32'(flags), 32'b1100);

        // CMP 0x05, 0x05
        preload(4'd4, 8'h05);
        preload(4'd5, 8'h05);
        run_op(4'hB, 4'd4, 4'd5, 4'd15, 16'h0000, d_at, ld, e_s);
        pin("cmp_done_cycle", 32'(d_at), 32'd6);
        pin("cmp_loads", 32'(ld), 32'd0);
        pin("cmp_flags", 32'(flags), 32'b0001);

        // SHR r6 -> r6
        preload(4'd6, 8'h81);
        run_op(4'h7, 4'd6, 4'd0, 4'd6, 16'h0000, d_at, ld, e_s);
        pin("shr_done_cycle", 32'(d_at), 32'd5);
        pin("shr_loads", 32'(ld), 32'd1);
        pin("shr_r6", 32'(rf[6]), 32'h40);
        pin("shr_flags", 32'(flags), 32'b0010);

        // Illegal opcode 0xE
        run_op(4'hE, 4'd1, 4'd2, 4'd3, 16'h0000, d_at, ld, e_s);
        pin("ill_done_cycle", 32'(d_at), 32'd1);
        pin("ill_loads", 32'(ld), 32'd0);
        pin("ill_err", 32'(e_s), 32'd1);
        pin("ill_r3_kept", 32'(rf[3]), 32'h80);
        pin("ill_flags_kept", 32'(flags), 32'b0010);

        // Reset during WRITE of SUB 0x00 - 0x01
        preload(4'd7, 8'h00);
        preload(4'd8, 8'h01);
        opcode = 4'h1;
        src_a = 4'd7;
        src_b = 4'd8;
        dst = 4'd9;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
        end
        pin("sub_write_load", 32'(reg_load), 32'd1);
        pin("sub_result", 32'(result), 32'hFF);
        pin("sub_flags", 32'(flags), 32'b1010);
        reset = 1'b1;
        @(posedge clock); #1;
        pin("abort_outputs", 32'({busy, done, err, result, flags, reg_addr, reg_load, reg_wdata}), 32'd0);
        reset = 1'b0;
        run_op(4'h0, 4'd1, 4'd2, 4'd10, 16'h0000, d_at, ld, e_s);
        pin("post_reset_done_cycle", 32'(d_at), 32'd7);
        pin("post_reset_r10", 32'(rf[10]), 32'h80);

        // ADD with stray start pulses in c2 and c5
        run_op(4'h0, 4'd1, 4'd2, 4'd11, 16'b0000_0000_0010_0100, d_at, ld, e_s);
        pin("pulse_done_cycle", 32'(d_at), 32'd7);
        pin("pulse_loads", 32'(ld), 32'd1);
        repeat (3) begin
            @(posedge clock); #1;
        end

        // Randomized instructions
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) preload(4'($urandom), pick_data());
            if ($urandom_range(0, 2) == 0) preload(4'($urandom), pick_data());
            run_op(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000, d_at, ld, e_s);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
